// File: rtl/pmp_pkg.sv
// pmp_pkg: shared definitions for the sequential PMP checker.
//   - pmpcfg byte bit positions (R/W/X/A/L)
//   - A-field encodings, access type encoding, checker FSM states
package pmp_pkg;

  localparam int unsigned CfgR   = 0;
  localparam int unsigned CfgW   = 1;
  localparam int unsigned CfgX   = 2;
  localparam int unsigned CfgALo = 3;
  localparam int unsigned CfgAHi = 4;
  localparam int unsigned CfgL   = 7;

  typedef enum logic [1:0] {
    AOff   = 2'd0,
    ATor   = 2'd1,
    ANa4   = 2'd2,
    ANapot = 2'd3
  } pmp_a_e;

  typedef enum logic [1:0] {
    AccRead  = 2'd0,
    AccWrite = 2'd1,
    AccExec  = 2'd2,
    AccRsvd  = 2'd3
  } acc_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// pmp_entry_match: combinational match of one access range against one PMP entry.
//   cfg       - pmpcfg byte of the entry
//   pmp_addr  - pmpaddr of the entry
//   prev_addr - pmpaddr of the preceding entry (0 for entry 0), TOR lower bound
//   lo, hi    - first and last byte of the access; hi < lo means the range wrapped
//   acc_type  - access kind selecting the R/W/X permission bit
//   full      - both lo and hi inside the region
//   partial   - exactly one of lo/hi inside the region
//   perm_ok   - entry grants the requested access kind
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [7:0]  cfg,
  input  logic [29:0] pmp_addr,
  input  logic [29:0] prev_addr,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  acc_type_e   acc_type,
  output logic        full,
  output logic        partial,
  output logic        perm_ok
);

  logic [31:0] cur_base;
  logic [31:0] prev_base;
  logic [29:0] napot_care;
  logic        wrapped;
  logic        lo_in;
  logic        hi_in;
  pmp_a_e      a_mode;

  assign a_mode    = pmp_a_e'(cfg[CfgAHi:CfgALo]);
  assign cur_base  = {pmp_addr, 2'b00};
  assign prev_base = {prev_addr, 2'b00};
  // Trailing ones plus the first zero are don't-care word-address bits; all ones -> whole space.
  assign napot_care = ~(pmp_addr ^ (pmp_addr + 30'd1));
  assign wrapped    = hi < lo;

  always_comb begin
    lo_in = 1'b0;
    hi_in = 1'b0;
    case (a_mode)
      ATor: begin
        lo_in = (lo >= prev_base) && (lo < cur_base);
        hi_in = (hi >= prev_base) && (hi < cur_base);
      end
      ANa4: begin
        lo_in = lo[31:2] == pmp_addr;
        hi_in = hi[31:2] == pmp_addr;
      end
      ANapot: begin
        lo_in = ((lo[31:2] ^ pmp_addr) & napot_care) == 30'd0;
        hi_in = ((hi[31:2] ^ pmp_addr) & napot_care) == 30'd0;
      end
      default: ;
    endcase
    // A wrapped end address lies outside every region.
    if (wrapped) begin
      hi_in = 1'b0;
    end
  end

  assign full    = lo_in & hi_in;
  assign partial = lo_in ^ hi_in;

  always_comb begin
    case (acc_type)
      AccRead:  perm_ok = cfg[CfgR];
      AccWrite: perm_ok = cfg[CfgW];
      AccExec:  perm_ok = cfg[CfgX];
      default:  perm_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_checker.sv
// pmp_seq_checker: walks PMP entries in priority order, one per cycle, through a single
// shared matcher; the first matching entry decides the verdict.
//   clock, reset_n                    - clock, asynchronous active-low reset
//   req_valid/req_ready               - request handshake
//   req_addr/req_size/req_type        - byte address, log2 bytes, access kind
//   req_mprv                          - 1 = machine mode, 0 = user mode
//   cfg_i/addr_i                      - live pmpcfg bytes and pmpaddr values
//   cfg_update                        - CSR write pulse, restarts an ongoing walk
//   resp_valid/resp_ready             - response handshake
//   resp_fault/resp_hit/resp_idx      - verdict, held stable until accepted
module pmp_seq_checker
  import pmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [1:0]                req_size,
  input  logic [1:0]                req_type,
  input  logic                      req_mprv,
  input  logic [8*NUM_ENTRIES-1:0]  cfg_i,
  input  logic [30*NUM_ENTRIES-1:0] addr_i,
  input  logic                      cfg_update,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_fault,
  output logic                      resp_hit,
  output logic [3:0]                resp_idx
);

  localparam logic [3:0] LastIdx = 4'(NUM_ENTRIES - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [31:0] lo_q;
  logic [1:0]  size_q;
  acc_type_e   type_q;
  logic        mprv_q;

  logic [31:0] hi;
  logic [7:0]  cur_cfg;
  logic [29:0] cur_addr;
  logic [29:0] prev_addr;
  logic        m_full;
  logic        m_partial;
  logic        m_perm_ok;
  logic        req_rsvd;

  assign hi       = lo_q + (32'd1 << size_q) - 32'd1;
  assign req_rsvd = (req_size == 2'd3) || (req_type == 2'd3);

  // Entry select mux feeding the shared matcher.
  always_comb begin
    cur_cfg   = '0;
    cur_addr  = '0;
    prev_addr = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (idx_q == 4'(i)) begin
        cur_cfg  = cfg_i[8*i +: 8];
        cur_addr = addr_i[30*i +: 30];
      end
    end
    for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
      if (idx_q == 4'(i)) begin
        prev_addr = addr_i[30*(i-1) +: 30];
      end
    end
  end

  pmp_entry_match u_match (
    .cfg       (cur_cfg),
    .pmp_addr  (cur_addr),
    .prev_addr (prev_addr),
    .lo        (lo_q),
    .hi        (hi),
    .acc_type  (type_q),
    .full      (m_full),
    .partial   (m_partial),
    .perm_ok   (m_perm_ok)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      lo_q       <= 32'd0;
      size_q     <= 2'd0;
      type_q     <= AccRead;
      mprv_q     <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            lo_q      <= req_addr;
            size_q    <= req_size;
            type_q    <= acc_type_e'(req_type);
            mprv_q    <= req_mprv;
            idx_q     <= 4'd0;
            req_ready <= 1'b0;
            if (req_rsvd) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_hit   <= 1'b0;
              resp_idx   <= 4'd0;
            end else begin
              state_q <= StWalk;
            end
          end
        end
        StWalk: begin
          if (cfg_update) begin
            // Config changed under us: this cycle's evaluation is stale, start over.
            idx_q <= 4'd0;
          end else if (m_full || m_partial) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_idx   <= idx_q;
            if (m_partial) begin
              resp_fault <= 1'b1;
            end else begin
              // Unlocked entries do not constrain machine mode.
              resp_fault <= (cur_cfg[CfgL] || !mprv_q) ? !m_perm_ok : 1'b0;
            end
          end else if (idx_q == LastIdx) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_idx   <= 4'd0;
            resp_fault <= !mprv_q;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pmp_seq_checker.md
# pmp_seq_checker

Sequential physical-memory-protection checker sitting between the core's load/store/fetch request path and the PMP configuration CSRs. Each request is checked by walking PMP entries in priority order, one entry per cycle, through a single shared entry matcher. The first matching entry decides the result, and the verdict is returned over a valid/ready response channel. This replaces a fully parallel per-entry compare with a time-multiplexed one for area-constrained configurations.

## Interface
- NUM_ENTRIES, 8, number of PMP entries (1..16)
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  check request valid
- req_ready  out  1  block can accept a request
- req_addr  in  32  physical byte address
- req_size  in  2  log2 access bytes: 0=1B, 1=2B, 2=4B; 3 is reserved and always faults
- req_type  in  2  0=read, 1=write, 2=execute; 3 is reserved and always faults
- req_mprv  in  1  1=machine mode, 0=user mode
- cfg_i  in  8*NUM_ENTRIES  pmpcfg bytes, entry i at [8i+7:8i]; bit0 R, bit1 W, bit2 X, bits4:3 A, bit7 L
- addr_i  in  30*NUM_ENTRIES  pmpaddr values, entry i at [30i+29:30i]
- cfg_update  in  1  single-cycle pulse: CSR write to any pmpcfg or pmpaddr
- resp_valid  out  1  verdict valid
- resp_ready  in  1  consumer accepts the verdict
- resp_fault  out  1  1 = access denied
- resp_hit  out  1  1 = some entry matched
- resp_idx  out  4  index of the matching entry (0 when resp_hit=0)

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, latch addr/size/type/mode, set idx=0, go to WALK.
  - WALK: evaluate entry idx.
    - On full match, or on a partial match, go to RESP.
    - On no match with idx<NUM_ENTRIES-1, increment idx.
    - On no match with idx==NUM_ENTRIES-1, go to RESP with hit=0.
  - RESP: resp_valid=1 with verdict held stable. On resp_ready, go to IDLE.
- Access range: lo=req_addr, hi=req_addr+(1<<req_size)-1. The addition is 32-bit and wraps; a wrapped hi counts as outside every region.
- A field decoding:
  - A=0 (OFF): never matches.
  - A=1 (TOR): the region is [prev, cur), where prev={addr_i[idx-1],2'b0} (0 for idx 0) and cur={addr_i[idx],2'b0}. An empty region when prev>=cur.
  - A=2 (NA4): the region is the 4 bytes at {addr,2'b0}.
  - A=3 (NAPOT): with t = number of trailing ones in pmpaddr, the region is 2^(t+3) bytes aligned. If pmpaddr is all ones, the region is the full 2^32 bytes.
- Match classes:
  - Full match: lo and hi both inside the region.
  - Partial match: exactly one of lo or hi is inside. This terminates the walk with fault=1, hit=1.
- Permission on a full match:
  - If L=1 or user mode, fault = !perm[req_type].
  - If machine mode and L=0, fault=0.
- No match: fault = !req_mprv.
- Reserved size or type: go to RESP directly from IDLE on the next cycle, with fault=1, hit=0, idx=0.
- cfg_update during WALK restarts the walk at idx=0 using the current cfg_i/addr_i. cfg_update in IDLE or RESP has no effect; a response already in RESP is committed.
- cfg_i and addr_i are used live, not snapshotted.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_hit=0, resp_idx=0.
- Request accepted at edge 0. Entry k is evaluated in cycle k+1. A decision at entry k gives resp_valid at cycle k+2.
- Worst-case latency is NUM_ENTRIES+1 cycles to resp_valid.
- req_ready=0 from acceptance until the cycle after the resp handshake. There is no request/response overlap; at most one request is outstanding.
- resp_* outputs are registered and stable while resp_valid=1 && !resp_ready.
- Asserting reset_n low mid-walk clears everything immediately. The in-flight request is dropped with no response.

## Structure
- Package pmp_pkg holds:
  - cfg bit positions (R/W/X/A/L)
  - A encodings OFF/TOR/NA4/NAPOT
  - access type enum and state enum
- One sub-module, pmp_entry_match: purely combinational.
  - Inputs: cfg byte, pmpaddr, previous pmpaddr, lo, hi.
  - Outputs: full, partial, perm_ok.
  - Instantiated once in this block and fed by an idx-selected mux.

## Test plan
- U-mode read at 0x8000_0010 size 2, entry 0 NAPOT pmpaddr=0x2000_0003 (32B at 0x8000_0000) with cfg R=1 → resp at cycle 2: fault=0, hit=1, idx=0.
- U-mode write to the same address with entry 2 matching NAPOT and W=0, and entries 0-1 OFF → resp at cycle 4: fault=1, hit=1, idx=2.
- M-mode exec at 0x1000, all entries OFF → resp at cycle 9 (NUM_ENTRIES=8): fault=0, hit=0. The same request in U-mode → fault=1.
- TOR entry 1 with addr0=0x400, addr1=0x800 (range 0x1000-0x1FFF), and a 4B read at 0x1FFE → partial match at idx 1 → fault=1, hit=1.
- cfg_update pulse at cycle 3 of a walk → walk restarts at idx 0. The response uses the new config and appears 3 cycles later than without the pulse.
- resp_ready held low for 5 cycles → resp_* stable and req_ready=0 throughout. reset_n low mid-walk → resp_valid=0 and req_ready=1 immediately.
